// File: rtl/fir_output_window_monitor_if.sv
// Sample-in / window-result-out bundle for fir_output_window_monitor.
// master drives samples (filter side), slave is the monitor itself.
interface fir_output_window_monitor_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 11
);
    logic                     enable;
    logic signed [DATA_W-1:0] d;
    logic                     busy;
    logic                     result_valid;
    logic signed [DATA_W-1:0] peak_max;
    logic signed [DATA_W-1:0] peak_min;
    logic        [DATA_W:0]   p2p;
    logic        [CNT_W-1:0]  zc_count;
    logic        [CNT_W-1:0]  sat_count;

    modport master (
        output enable, d,
        input  busy, result_valid, peak_max, peak_min, p2p, zc_count, sat_count
    );

    modport slave (
        input  enable, d,
        output busy, result_valid, peak_max, peak_min, p2p, zc_count, sat_count
    );
endinterface

// File: rtl/fir_output_window_monitor.sv
// Per-window max/min/peak-to-peak/zero-crossing monitor for the FIR output stream.
// Optional macro MONITOR_SAT_COUNT_EN adds a per-window full-scale sample counter.
module fir_output_window_monitor #(
    parameter int DATA_W        = 16,
    parameter int WINDOW_LEN    = 1024,
    parameter int CNT_W         = 11,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    fir_output_window_monitor_if.slave   mon
);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM} state_t;

    state_t                   state_q, state_d;
    logic [SET_W-1:0]         settle_cnt_q, settle_cnt_d;
    logic                     take;

    logic signed [DATA_W-1:0] run_max_q, run_max_d, run_min_q, run_min_d;
    logic                     prev_sign_q, prev_sign_d;
    logic [CNT_W-1:0]         win_cnt_q, win_cnt_d, zc_run_q, zc_run_d;
    logic                     win_last;

    logic signed [DATA_W-1:0] peak_max_q, peak_min_q;
    logic [DATA_W:0]          p2p_q;
    logic [CNT_W-1:0]         zc_count_q;
    logic                     result_valid_q;

    // Sign-extend both operands so full-scale swing fits without wrap.
    function automatic logic [DATA_W:0] calc_p2p(input logic signed [DATA_W-1:0] hi,
                                                 input logic signed [DATA_W-1:0] lo);
        return {hi[DATA_W-1], hi} - {lo[DATA_W-1], lo};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    // The first accepted sample after reset already counts toward settle or the window.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        take         = 1'b0;
        case (state_q)
            IDLE: if (mon.enable) begin
                if (SETTLE_CYCLES == 0) begin
                    state_d = ACCUM;
                    take    = 1'b1;
                end else if (SETTLE_CYCLES == 1) begin
                    state_d = ACCUM;
                end else begin
                    state_d      = SETTLE;
                    settle_cnt_d = SET_W'(1);
                end
            end
            SETTLE: if (mon.enable) begin
                settle_cnt_d = settle_cnt_q + SET_W'(1);
                if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) state_d = ACCUM;
            end
            ACCUM:   take = mon.enable;
            default: state_d = IDLE;
        endcase
    end

`ifdef MONITOR_SAT_COUNT_EN
    logic [CNT_W-1:0] sat_run_q, sat_run_d, sat_count_q;

    function automatic logic is_full_scale(input logic signed [DATA_W-1:0] x);
        return (x == {1'b0, {(DATA_W-1){1'b1}}}) || (x == {1'b1, {(DATA_W-1){1'b0}}});
    endfunction
`endif

    always_comb begin
        run_max_d   = run_max_q;
        run_min_d   = run_min_q;
        prev_sign_d = prev_sign_q;
        zc_run_d    = zc_run_q;
        win_cnt_d   = win_cnt_q;
        win_last    = 1'b0;
`ifdef MONITOR_SAT_COUNT_EN
        sat_run_d   = sat_run_q;
`endif
        if (take) begin
            win_last    = (win_cnt_q == CNT_W'(WINDOW_LEN - 1));
            win_cnt_d   = win_last ? '0 : win_cnt_q + CNT_W'(1);
            prev_sign_d = mon.d[DATA_W-1];
            // Window sample 1 reseeds everything; no crossing against the previous window.
            if (win_cnt_q == '0) begin
                run_max_d = mon.d;
                run_min_d = mon.d;
                zc_run_d  = '0;
`ifdef MONITOR_SAT_COUNT_EN
                sat_run_d = CNT_W'(is_full_scale(mon.d));
`endif
            end else begin
                if (mon.d > run_max_q) run_max_d = mon.d;
                if (mon.d < run_min_q) run_min_d = mon.d;
                if (mon.d[DATA_W-1] != prev_sign_q) zc_run_d = zc_run_q + CNT_W'(1);
`ifdef MONITOR_SAT_COUNT_EN
                sat_run_d = sat_run_q + CNT_W'(is_full_scale(mon.d));
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_max_q      <= '0;
            run_min_q      <= '0;
            prev_sign_q    <= 1'b0;
            zc_run_q       <= '0;
            win_cnt_q      <= '0;
            peak_max_q     <= '0;
            peak_min_q     <= '0;
            p2p_q          <= '0;
            zc_count_q     <= '0;
            result_valid_q <= 1'b0;
        end else begin
            run_max_q      <= run_max_d;
            run_min_q      <= run_min_d;
            prev_sign_q    <= prev_sign_d;
            zc_run_q       <= zc_run_d;
            win_cnt_q      <= win_cnt_d;
            result_valid_q <= take && win_last;
            if (take && win_last) begin
                peak_max_q <= run_max_d;
                peak_min_q <= run_min_d;
                p2p_q      <= calc_p2p(run_max_d, run_min_d);
                zc_count_q <= zc_run_d;
            end
        end
    end

`ifdef MONITOR_SAT_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_run_q   <= '0;
            sat_count_q <= '0;
        end else begin
            sat_run_q <= sat_run_d;
            if (take && win_last) sat_count_q <= sat_run_d;
        end
    end

    assign mon.sat_count = sat_count_q;
`else
    assign mon.sat_count = '0;
`endif

    assign mon.busy         = (state_q != IDLE);
    assign mon.result_valid = result_valid_q;
    assign mon.peak_max     = peak_max_q;
    assign mon.peak_min     = peak_min_q;
    assign mon.p2p          = p2p_q;
    assign mon.zc_count     = zc_count_q;
endmodule
